// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
//   Transmit stage behind the memory-mapped UART write device. Bytes arrive on
//   a valid/ready stream, are buffered in a small FIFO and are serialized onto
//   an asynchronous line. The frame is 8N1, LSB first, with a fixed baud divisor.
//
// Parameters
//   CLK_DIV    : clk cycles per serial bit (>= 2)
//   FIFO_DEPTH : byte FIFO entries (power of 2, >= 2)
//
// Ports
//   clk      : clock, all logic on posedge
//   rst      : synchronous reset, active-high (aborts any frame, flushes FIFO)
//   in_valid : byte offered by the UART device
//   in_ready : FIFO can accept a byte (= !full)
//   in_data  : byte to transmit
//   tx       : serial line, idle high, registered
//   busy     : frame in flight or FIFO non-empty
//   level    : current FIFO occupancy
//
// Optional feature
//   UART_TX_PARITY_EN : when defined, an even-parity bit is inserted between the
//                       data bits and the stop bit (11*CLK_DIV frame).

module uart_tx_serializer #(
    parameter int CLK_DIV    = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [7:0]                    in_data,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   level
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(CLK_DIV - 1);
    localparam logic [AW:0]   FULL_LVL = (AW + 1)'(FIFO_DEPTH);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   level_r;

    logic [2:0]    state;
    logic [CW-1:0] bit_cnt;
    logic [2:0]    idx;
    logic [7:0]    sh;
    logic          tx_r;
`ifdef UART_TX_PARITY_EN
    logic          par_r;
`endif

    logic       full;
    logic       empty;
    logic       push;
    logic       pop;
    logic       bit_end;
    logic [7:0] head;

    assign full    = (level_r == FULL_LVL);
    assign empty   = (level_r == '0);
    assign push    = in_valid && !full;
    assign bit_end = (bit_cnt == BIT_LAST);
    assign head    = mem[rd_ptr];
    // A pop happens either from IDLE or at the last cycle of the stop bit. The
    // second case chains frames back-to-back with no idle gap.
    assign pop     = !empty && ((state == S_IDLE) || ((state == S_STOP) && bit_end));

    assign in_ready = !full;
    assign level    = level_r;
    assign busy     = (state != S_IDLE) || !empty;
    assign tx       = tx_r;

    // Storage has no reset so it can map onto distributed RAM.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_r <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   level_r <= level_r + (AW + 1)'(1);
                2'b01:   level_r <= level_r - (AW + 1)'(1);
                default: level_r <= level_r;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= S_IDLE;
            bit_cnt <= '0;
            idx     <= '0;
            sh      <= '0;
            tx_r    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_r   <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    bit_cnt <= '0;
                    if (pop) begin
                        sh    <= head;
`ifdef UART_TX_PARITY_EN
                        par_r <= ^head;
`endif
                        state <= S_START;
                        tx_r  <= 1'b0;
                    end
                end
                S_START: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        idx     <= '0;
                        state   <= S_DATA;
                        tx_r    <= sh[0];
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                S_DATA: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            state <= S_PARITY;
                            tx_r  <= par_r;
`else
                            state <= S_STOP;
                            tx_r  <= 1'b1;
`endif
                        end else begin
                            // sh[1] is the bit that lands in sh[0] after this shift.
                            sh   <= sh >> 1;
                            tx_r <= sh[1];
                            idx  <= idx + 3'd1;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        state   <= S_STOP;
                        tx_r    <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (bit_end) begin
                        bit_cnt <= '0;
                        if (pop) begin
                            sh    <= head;
`ifdef UART_TX_PARITY_EN
                            par_r <= ^head;
`endif
                            state <= S_START;
                            tx_r  <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                default: begin
                    state   <= S_IDLE;
                    bit_cnt <= '0;
                    tx_r    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_serializer.sv
module tb_uart_tx_serializer;

    localparam int CLK_DIV = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, tx, busy;
    logic [7:0] in_data;
    logic [2:0] level;

    logic       in_valid2, in_ready2, tx2, busy2;
    logic [7:0] in_data2;
    logic [2:0] level2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    uart_tx_serializer #(.CLK_DIV(4), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .tx(tx), .busy(busy), .level(level)
    );

    uart_tx_serializer #(.CLK_DIV(2), .FIFO_DEPTH(4)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
        .in_data(in_data2), .tx(tx2), .busy(busy2), .level(level2)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Expected line value during bit b of a frame carrying d.
    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0)
            return 1'b0;
        else if (b <= 8)
            return d[b-1];
`ifdef UART_TX_PARITY_EN
        else if (b == 9)
            return ^d;
`endif
        else
            return 1'b1;
    endfunction

    // Called one step after the pop edge; returns one step after the frame's last edge.
    task automatic frame(input logic [7:0] d, input string tag);
        for (int b = 0; b < NB; b++) begin
            chk($sformatf("%s_bit%0d", tag, b), {31'd0, tx}, {31'd0, exp_bit(d, b)});
            for (int c = 0; c < CLK_DIV; c++) begin
                if (b == NB - 1 && c == CLK_DIV - 1)
                    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd1);
                tick(1);
                in_valid = 1'b0;
            end
        end
    endtask

    initial begin
        logic saw_low;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00;
        in_valid2 = 1'b0; in_data2 = 8'h00;
        tick(2);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_level", {29'd0, level}, 32'd0);
        chk("rst_tx2", {31'd0, tx2}, 32'd1);
        rst = 1'b0;
        tick(1);

        // 1. single byte
        in_data = 8'h55; in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        chk("t1_level_push", {29'd0, level}, 32'd1);
        chk("t1_tx_before_pop", {31'd0, tx}, 32'd1);
        chk("t1_busy_queued", {31'd0, busy}, 32'd1);
        tick(1);
        frame(8'h55, "t1");
        chk("t1_busy_after", {31'd0, busy}, 32'd0);
        chk("t1_tx_idle", {31'd0, tx}, 32'd1);
        tick(3);

        // 2. back-to-back
        in_data = 8'h41; in_valid = 1'b1;
        tick(1);
        in_data = 8'h42;
        chk("t2_level_a", {29'd0, level}, 32'd1);
        tick(1);
        in_valid = 1'b0;
        chk("t2_level_b", {29'd0, level}, 32'd1);
        frame(8'h41, "t2a");
        chk("t2_level_c", {29'd0, level}, 32'd0);
        frame(8'h42, "t2b");
        chk("t2_busy_after", {31'd0, busy}, 32'd0);
        tick(2);

        // 3. full FIFO with a held 5th byte
        in_data = 8'h00; in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        tick(1);
        chk("t3_tx_start", {31'd0, tx}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            in_data = 8'(k); in_valid = 1'b1;
            tick(1);
        end
        in_data = 8'h05;
        chk("t3_level_full", {29'd0, level}, 32'd4);
        chk("t3_ready_full", {31'd0, in_ready}, 32'd0);
        tick(35);
        chk("t3_ready_held", {31'd0, in_ready}, 32'd0);
        chk("t3_level_held", {29'd0, level}, 32'd4);
        tick(1);
        chk("t3_level_pop", {29'd0, level}, 32'd3);
        chk("t3_ready_pop", {31'd0, in_ready}, 32'd1);
        frame(8'h01, "t3_01");
        chk("t3_level_after5", {29'd0, level}, 32'd3);
        frame(8'h02, "t3_02");
        frame(8'h03, "t3_03");
        frame(8'h04, "t3_04");
        frame(8'h05, "t3_05");
        chk("t3_busy_after", {31'd0, busy}, 32'd0);
        chk("t3_level_empty", {29'd0, level}, 32'd0);
        tick(2);

`ifdef UART_TX_PARITY_EN
        // 5. parity
        in_data = 8'h07; in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        tick(1);
        frame(8'h07, "t5_07");
        in_data = 8'h55; in_valid = 1'b1;
        tick(1);
        in_valid = 1'b0;
        tick(1);
        frame(8'h55, "t5_55");
        chk("t5_busy_after", {31'd0, busy}, 32'd0);
        tick(2);
`endif

        // 4. reset mid-frame
        in_data = 8'hA3; in_valid = 1'b1;
        tick(1);
        in_data = 8'h11;
        tick(1);
        in_data = 8'h22;
        tick(1);
        in_valid = 1'b0;
        chk("t4_level_q", {29'd0, level}, 32'd2);
        tick(14);
        chk("t4_tx_cycle15", {31'd0, tx}, 32'd0);
        rst = 1'b1;
        tick(1);
        chk("t4_tx", {31'd0, tx}, 32'd1);
        chk("t4_level", {29'd0, level}, 32'd0);
        chk("t4_busy", {31'd0, busy}, 32'd0);
        chk("t4_ready", {31'd0, in_ready}, 32'd1);
        rst = 1'b0;
        saw_low = 1'b0;
        for (int i = 0; i < 60; i++) begin
            tick(1);
            if (tx !== 1'b1)
                saw_low = 1'b1;
        end
        chk("t4_no_frame", {31'd0, saw_low}, 32'd0);
        chk("t4_busy_idle", {31'd0, busy}, 32'd0);

        // 6. CLK_DIV=2
        in_data2 = 8'hFF; in_valid2 = 1'b1;
        tick(1);
        in_valid2 = 1'b0;
        tick(1);
        for (int c = 0; c < 2 * NB; c++) begin
            chk($sformatf("t6_tx_c%0d", c), {31'd0, tx2}, {31'd0, exp_bit(8'hFF, c / 2)});
            chk($sformatf("t6_busy_c%0d", c), {31'd0, busy2}, 32'd1);
            tick(1);
        end
        chk("t6_busy_after", {31'd0, busy2}, 32'd0);
        chk("t6_tx_idle", {31'd0, tx2}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Physical-side transmit stage downstream of the memory-mapped UART write device.
- Consumes bytes the device produces over a valid/ready byte stream and buffers them in a small FIFO.
- Serializes each byte onto a single asynchronous line: 8N1 by default, LSB first, fixed baud divisor.
- Replaces the simulation-only character print in FPGA builds. The device's bvalid may be gated on in_ready.

Parameters:
- CLK_DIV, 16: clk cycles per serial bit. Legal range ≥ 2.
- FIFO_DEPTH, 8: byte FIFO entries. Power of 2, ≥ 2.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  byte offered by the UART device.
- in_ready  output  1  FIFO can accept a byte (= !full).
- in_data  input  8  byte to transmit (device's wdata[7:0]).
- tx  output  1  serial line, idle high, registered.
- busy  output  1  frame in flight or FIFO non-empty.
- level  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
Reset:
- tx=1, in_ready=1, busy=0, level=0, state=IDLE, FIFO pointers=0.
- Reset mid-frame aborts the frame. tx=1 from the cycle after the reset edge, and the FIFO is flushed.

FIFO:
- Push on posedge when in_valid && in_ready. in_data must be stable while in_valid is high and in_ready is low.
- Pointers wrap modulo FIFO_DEPTH.
- Full when level==FIFO_DEPTH; empty when level==0.
- Push and pop in the same cycle: level unchanged, both pointers advance.
- No push when full. Pop never occurs when empty.

FSM states:
- IDLE, START, DATA, STOP (plus PARITY under the optional feature).
- bit_cnt: counts 0..CLK_DIV-1 within each bit.
- idx: 0..7, current data bit.

Transitions:
- IDLE & !empty: pop head into an 8-bit shift register, go to START, tx<=0.
- START: after CLK_DIV cycles, go to DATA, tx<=sh[0].
- DATA: each CLK_DIV cycles, shift right and drive the next bit. After bit 7 has held CLK_DIV cycles, go to STOP, tx<=1.
- STOP: held CLK_DIV cycles, then:
  - FIFO non-empty: pop and go directly to START (tx<=0), with no idle gap.
  - FIFO empty: go to IDLE, tx stays 1.

Timing:
- Byte pushed into an empty FIFO at edge E0 is popped at E1. tx falls after E1.
- Frame is exactly 10*CLK_DIV cycles.
- Back-to-back frames are contiguous.
- busy = (state!=IDLE) | (level!=0).
- Pushes may continue during transmission. in_ready reflects only FIFO fullness.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - It drives even parity (XOR of the 8 data bits) for CLK_DIV cycles.
  - Frame length becomes 11*CLK_DIV.
- Undefined:
  - No PARITY state, 8N1 format, 10*CLK_DIV frame.

Test Plan (CLK_DIV=4, FIFO_DEPTH=4 unless noted):
1. Single byte: push 0x55 into an idle block.
   - tx falls 1 cycle after acceptance.
   - Sampled every 4 cycles, tx reads 0,1,0,1,0,1,0,1,0,1 (start, LSB-first data, stop).
   - busy drops after 40 cycles.
2. Back-to-back: push 0x41, 0x42 on consecutive cycles.
   - Two contiguous 40-cycle frames with no idle-high gap between stop and start.
   - level goes 1,1,0 (second push overlaps the first pop), then 0.
3. Full FIFO: while 0x00 transmits, push 0x01..0x04.
   - in_ready=0 at level=4. A 5th offered byte (0x05) is held and accepted only after the next pop.
   - Output order is 0x00,0x01,0x02,0x03,0x04,0x05.
4. Reset mid-frame: assert rst at cycle 15 of the 0xA3 frame with 2 bytes queued.
   - Next cycle: tx=1, level=0, busy=0, in_ready=1.
   - No further frame is produced.
5. Parity (UART_TX_PARITY_EN):
   - Push 0x07: the parity bit is 1 during cycles 36–39 of the frame, stop occupies 40–43, total 44 cycles.
   - Push 0x55: parity bit is 0.
6. Divider edge: CLK_DIV=2, push 0xFF → tx reads 0 for 2 cycles, then 1 for 18 cycles. busy is high for exactly 20 cycles after the pop.
